// File: rtl/dmem_arb_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, the latched
// request record and the default port widths.
package dmem_arb_pkg;

  localparam int unsigned DMEM_ADDR_W = 64;
  localparam int unsigned DMEM_DATA_W = 64;
  localparam int unsigned DMEM_SIZE_W = $clog2(DMEM_DATA_W / 8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef struct packed {
    logic                   we;
    logic [DMEM_ADDR_W-1:0] addr;
    logic [DMEM_SIZE_W-1:0] wr_size;
    logic [DMEM_DATA_W-1:0] wr_data;
  } req_t;

endpackage

// File: rtl/dmem_arbiter_rr.sv
// Combinational round-robin grant: searches upward from last_ptr+1 (mod N)
// and returns a one-hot grant plus its encoded index.
module rr_arbiter #(
  parameter  int unsigned N     = 2,
  localparam int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic             en,
  input  logic [IDX_W-1:0] last_ptr,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  always_comb begin : search
    int unsigned idx;
    logic        found;
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(last_ptr) + i + 1) % N;
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = IDX_W'(idx);
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one pulse-enable busy/rdy data-memory port between NUM_REQ requesters.
// Optional watchdog on the WAIT state: define DMEM_ARB_TIMEOUT_EN.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter  int unsigned DATA_WIDTH     = 64,
  parameter  int unsigned FETCH_WIDTH    = 64,
  parameter  int unsigned NUM_REQ        = 2,
  parameter  int unsigned TIMEOUT_CYCLES = 256,
  localparam int unsigned SIZE_W         = $clog2(FETCH_WIDTH / 8),
  localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic [NUM_REQ-1:0]                   req_valid_i,
  input  logic [NUM_REQ-1:0]                   req_we_i,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]   req_addr_i,
  input  logic [NUM_REQ-1:0][SIZE_W-1:0]       req_wr_size_i,
  input  logic [NUM_REQ-1:0][FETCH_WIDTH-1:0]  req_wr_data_i,
  output logic [NUM_REQ-1:0]                   req_ready_o,
  output logic [NUM_REQ-1:0]                   resp_valid_o,
  output logic [FETCH_WIDTH-1:0]               resp_rd_data_o,
  output logic                                 resp_err_o,
  output logic                                 mem_rd_en_o,
  output logic                                 mem_wr_en_o,
  output logic [DATA_WIDTH-1:0]                mem_addr_o,
  output logic [SIZE_W-1:0]                    mem_wr_size_o,
  output logic [FETCH_WIDTH-1:0]               mem_wr_data_o,
  input  logic                                 mem_busy_i,
  input  logic                                 mem_rdy_i,
  input  logic [FETCH_WIDTH-1:0]               mem_rd_data_i
);

  // The latched request record uses the package widths.
  if (NUM_REQ < 2 || TIMEOUT_CYCLES < 1 ||
      DATA_WIDTH != DMEM_ADDR_W || FETCH_WIDTH != DMEM_DATA_W) begin : g_bad_params
    $error("dmem_arbiter: unsupported parameter set");
  end

  state_t                 state;
  req_t                   lat;
  logic [IDX_W-1:0]       rr_ptr;
  logic [IDX_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]     gnt;
  logic [FETCH_WIDTH-1:0] rd_buf;
  logic                   arb_en;
  logic                   accept;
  logic                   hold_mem;
  logic                   wait_done;

  // Gating with rst_n keeps req_ready_o low while reset is held.
  assign arb_en = rst_n && (state == IDLE) && !mem_busy_i;

  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .req      (req_valid_i),
    .en       (arb_en),
    .last_ptr (rr_ptr),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx)
  );

  assign accept      = |gnt;
  assign req_ready_o = gnt;

`ifdef DMEM_ARB_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] wait_cnt;
  logic             timed_out;
  logic             err_q;

  assign timed_out = (state == WAIT) && !mem_rdy_i &&
                     (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else begin
      if (state == ISSUE) wait_cnt <= '0;
      else if (state == WAIT) wait_cnt <= wait_cnt + CNT_W'(1);
      if (timed_out) err_q <= 1'b1;
      else if (state == RESP) err_q <= 1'b0;
    end
  end

  assign wait_done  = mem_rdy_i || timed_out;
  assign resp_err_o = (state == RESP) && err_q;
`else
  assign wait_done  = mem_rdy_i;
  assign resp_err_o = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      lat    <= '0;
      rr_ptr <= '0;
      rd_buf <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            lat.we      <= req_we_i[gnt_idx];
            lat.addr    <= req_addr_i[gnt_idx];
            lat.wr_size <= req_wr_size_i[gnt_idx];
            lat.wr_data <= req_wr_data_i[gnt_idx];
            rr_ptr      <= gnt_idx;
            state       <= ISSUE;
          end
        end
        ISSUE: state <= WAIT;
        WAIT: begin
          if (wait_done) begin
            // A timeout reaches here without rdy, so its data is forced to 0.
            rd_buf <= (mem_rdy_i && !lat.we) ? mem_rd_data_i : '0;
            state  <= RESP;
          end
        end
        RESP: begin
          rd_buf <= '0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    hold_mem       = (state == ISSUE) || (state == WAIT);
    mem_rd_en_o    = (state == ISSUE) && !lat.we;
    mem_wr_en_o    = (state == ISSUE) && lat.we;
    mem_addr_o     = hold_mem ? lat.addr    : '0;
    mem_wr_size_o  = hold_mem ? lat.wr_size : '0;
    mem_wr_data_o  = hold_mem ? lat.wr_data : '0;
    resp_valid_o   = '0;
    resp_rd_data_o = '0;
    if (state == RESP) begin
      resp_valid_o[rr_ptr] = 1'b1;
      resp_rd_data_o       = rd_buf;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a small busy/rdy memory model;
// the watchdog case runs only when DMEM_ARB_TIMEOUT_EN is defined.
module tb_dmem_arbiter;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [1:0]       req_valid_i;
  logic [1:0]       req_we_i;
  logic [1:0][63:0] req_addr_i;
  logic [1:0][2:0]  req_wr_size_i;
  logic [1:0][63:0] req_wr_data_i;
  logic [1:0]       req_ready_o;
  logic [1:0]       resp_valid_o;
  logic [63:0]      resp_rd_data_o;
  logic             resp_err_o;
  logic             mem_rd_en_o;
  logic             mem_wr_en_o;
  logic [63:0]      mem_addr_o;
  logic [2:0]       mem_wr_size_o;
  logic [63:0]      mem_wr_data_o;
  logic             mem_busy_i;
  logic             mem_rdy_i;
  logic [63:0]      mem_rd_data_i;

  logic             force_busy = 1'b0;
  logic             no_rdy     = 1'b0;
  logic [63:0]      mem_data   = '0;
  int               n_checks   = 0;
  int               n_pass     = 0;

  dmem_arbiter #(
    .DATA_WIDTH     (64),
    .FETCH_WIDTH    (64),
    .NUM_REQ        (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid_i    (req_valid_i),
    .req_we_i       (req_we_i),
    .req_addr_i     (req_addr_i),
    .req_wr_size_i  (req_wr_size_i),
    .req_wr_data_i  (req_wr_data_i),
    .req_ready_o    (req_ready_o),
    .resp_valid_o   (resp_valid_o),
    .resp_rd_data_o (resp_rd_data_o),
    .resp_err_o     (resp_err_o),
    .mem_rd_en_o    (mem_rd_en_o),
    .mem_wr_en_o    (mem_wr_en_o),
    .mem_addr_o     (mem_addr_o),
    .mem_wr_size_o  (mem_wr_size_o),
    .mem_wr_data_o  (mem_wr_data_o),
    .mem_busy_i     (mem_busy_i),
    .mem_rdy_i      (mem_rdy_i),
    .mem_rd_data_i  (mem_rd_data_i)
  );

  always #5 clk = ~clk;

  // Memory: rdy two cycles after a read pulse, 2+size after a write pulse.
  initial begin : mem_model
    int   pend;
    logic active;
    pend          = 0;
    active        = 1'b0;
    mem_busy_i    = 1'b0;
    mem_rdy_i     = 1'b0;
    mem_rd_data_i = '0;
    forever begin
      @(negedge clk);
      if (mem_rd_en_o) begin
        pend = 2; active = 1'b1;
      end else if (mem_wr_en_o) begin
        pend = 2 + int'(mem_wr_size_o); active = 1'b1;
      end
      @(posedge clk); #2;
      mem_rdy_i     = 1'b0;
      mem_rd_data_i = '0;
      if (active) begin
        pend--;
        if (pend == 0) begin
          active = 1'b0;
          if (!no_rdy) begin
            mem_rdy_i     = 1'b1;
            mem_rd_data_i = mem_data;
          end
        end
      end
      mem_busy_i = force_busy || active || mem_rdy_i;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic logic [1:0] oh(input int r);
    oh = 2'b01 << r;
  endfunction

  // Single requester transaction; k counts cycles from raising valid.
  task automatic do_txn(input string tag, input int r, input logic we,
                        input logic [63:0] addr, input logic [2:0] size,
                        input logic [63:0] wdata, input logic [63:0] mdata,
                        input logic [63:0] exp_rdata, input int exp_acc,
                        input int exp_lat, input logic exp_err);
    int acc, iss, rsp, n_pulse;
    acc = -1; iss = -1; rsp = -1; n_pulse = 0;
    mem_data          = mdata;
    req_we_i[r]       = we;
    req_addr_i[r]     = addr;
    req_wr_size_i[r]  = size;
    req_wr_data_i[r]  = wdata;
    req_valid_i[r]    = 1'b1;
    for (int k = 0; k < 400 && rsp < 0; k++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00 && acc < 0) begin
        acc = k;
        check({tag, ".ready"}, 64'(req_ready_o), 64'(oh(r)));
      end
      if (mem_rd_en_o || mem_wr_en_o) begin
        n_pulse++;
        if (iss < 0) begin
          iss = k;
          check({tag, ".rd_en"}, 64'(mem_rd_en_o), 64'(!we));
          check({tag, ".wr_en"}, 64'(mem_wr_en_o), 64'(we));
          check({tag, ".addr"},  mem_addr_o, addr);
          if (we) begin
            check({tag, ".size"},  64'(mem_wr_size_o), 64'(size));
            check({tag, ".wdata"}, mem_wr_data_o, wdata);
          end
        end
      end
      if (resp_valid_o != 2'b00) begin
        rsp = k;
        check({tag, ".resp_valid"}, 64'(resp_valid_o), 64'(oh(r)));
        check({tag, ".resp_data"},  resp_rd_data_o, exp_rdata);
        check({tag, ".resp_err"},   64'(resp_err_o), 64'(exp_err));
      end
      tick();
      if (acc >= 0) req_valid_i[r] = 1'b0;
    end
    req_valid_i[r] = 1'b0;
    check({tag, ".acc_cycle"},  64'(acc), 64'(exp_acc));
    check({tag, ".issue_cyc"},  64'(iss), 64'(exp_acc + 1));
    check({tag, ".pulses"},     64'(n_pulse), 64'd1);
    check({tag, ".resp_cyc"},   64'(rsp), 64'(exp_acc + exp_lat));
    @(negedge clk);
    check({tag, ".idle_valid"}, 64'(resp_valid_o), 64'd0);
    check({tag, ".idle_data"},  resp_rd_data_o, 64'd0);
    check({tag, ".idle_addr"},  mem_addr_o, 64'd0);
    tick();
  endtask

  // Both requesters hold valid for n grants: req0 reads, req1 writes.
  task automatic alt_run(input string tag, input int n, input int first);
    int q[$];
    int nxt, granted, done, er;
    nxt = first; granted = 0; done = 0;
    mem_data         = 64'hCAFE_F00D_0000_1234;
    req_we_i         = 2'b10;
    req_addr_i[0]    = 64'h200;
    req_addr_i[1]    = 64'h300;
    req_wr_size_i[1] = 3'd0;
    req_wr_data_i[1] = 64'h55;
    req_valid_i      = 2'b11;
    for (int k = 0; k < 400 && done < n; k++) begin
      @(negedge clk);
      if (req_ready_o != 2'b00) begin
        check($sformatf("%s.grant%0d", tag, granted), 64'(req_ready_o), 64'(oh(nxt)));
        q.push_back(nxt);
        nxt = 1 - nxt;
        granted++;
      end
      if (resp_valid_o != 2'b00) begin
        er = (q.size() > 0) ? q.pop_front() : 3;
        check($sformatf("%s.resp%0d", tag, done), 64'(resp_valid_o), 64'(oh(er)));
        check($sformatf("%s.data%0d", tag, done), resp_rd_data_o,
              (er == 0) ? 64'hCAFE_F00D_0000_1234 : 64'd0);
        done++;
      end
      tick();
      if (granted >= n) req_valid_i = 2'b00;
    end
    req_valid_i = 2'b00;
    check({tag, ".responses"}, 64'(done), 64'(n));
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int stray;
    rst_n         = 1'b0;
    req_valid_i   = '0;
    req_we_i      = '0;
    req_addr_i    = '0;
    req_wr_size_i = '0;
    req_wr_data_i = '0;
    repeat (2) tick();
    @(negedge clk);
    check("reset.ready",   64'(req_ready_o), 64'd0);
    check("reset.resp",    64'(resp_valid_o), 64'd0);
    check("reset.mem_en",  64'({mem_rd_en_o, mem_wr_en_o}), 64'd0);
    check("reset.addr",    mem_addr_o, 64'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    do_txn("rd0", 0, 1'b0, 64'h40, 3'd0, 64'd0, 64'h1122334455667788,
           64'h1122334455667788, 0, 4, 1'b0);
    do_txn("wr1", 1, 1'b1, 64'h10, 3'd3, 64'hAABBCCDD, 64'hFFFF_0000_FFFF_0000,
           64'd0, 0, 7, 1'b0);
    alt_run("alt", 6, 0);

    force_busy = 1'b1;
    tick();
    fork
      do_txn("busy", 0, 1'b0, 64'h500, 3'd0, 64'd0, 64'h0123456789ABCDEF,
             64'h0123456789ABCDEF, 5, 4, 1'b0);
      begin
        repeat (5) tick();
        force_busy = 1'b0;
      end
    join

    // Reset while the read sits in WAIT; its rdy arrives after release.
    mem_data       = 64'h7777;
    req_we_i[0]    = 1'b0;
    req_addr_i[0]  = 64'h80;
    req_valid_i[0] = 1'b1;
    @(negedge clk);
    check("rstw.ready", 64'(req_ready_o), 64'(2'b01));
    tick();
    req_valid_i[0] = 1'b0;
    tick();
    #1 rst_n = 1'b0;
    #1;
    check("rstw.addr",   mem_addr_o, 64'd0);
    check("rstw.mem_en", 64'({mem_rd_en_o, mem_wr_en_o}), 64'd0);
    check("rstw.resp",   64'(resp_valid_o), 64'd0);
    check("rstw.data",   resp_rd_data_o, 64'd0);
    #1 rst_n = 1'b1;
    stray = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (resp_valid_o != 2'b00) stray++;
    end
    check("rstw.stray_resp", 64'(stray), 64'd0);
    tick();
    alt_run("post_rst", 2, 1);

`ifdef DMEM_ARB_TIMEOUT_EN
    no_rdy = 1'b1;
    do_txn("tmo", 1, 1'b0, 64'h600, 3'd0, 64'd0, 64'hDEAD, 64'd0, 0, 10, 1'b1);
    no_rdy = 1'b0;
    do_txn("after_tmo", 0, 1'b0, 64'h700, 3'd0, 64'd0, 64'h5A5A,
           64'h5A5A, 0, 4, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
